gpr_wb_arbiter: RTL and testbench

Writeback arbiter directly upstream of the two-write-port GPR file. Merges three writeback sources into GPR write ports 0/1: single-cycle ALU results, load data from the LSU, and multi-cycle MUL/DIV results from the MDU. It registers the merged writes, so ports change only on clock edges. It also owns an optional per-register pending scoreboard that decode uses to stall RAW hazards.

---
 rtl/gpr_wb_arbiter_pkg.sv | 32 +++
 rtl/gpr_wb_arbiter_scoreboard.sv | 42 ++++
 rtl/gpr_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR writeback arbiter: widths, source ids, request record
// and the scoreboard busy query.
package gpr_wb_arbiter_pkg;

    localparam int GPR_DEPTH = 5;
    localparam int GPR_WIDTH = 32;
    localparam int GPR_SIZE  = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    localparam src_e RR_RST = SRC_LSU;

    typedef struct packed {
        logic                 vld;
        logic [GPR_DEPTH-1:0] waddr;
        logic [GPR_WIDTH-1:0] wd;
    } wb_req_t;

    // A register being written this cycle reads as not busy: the GPR read bypass supplies it.
    function automatic logic f_busy(input logic [GPR_SIZE-1:0]  pend,
                                    input logic [GPR_DEPTH-1:0] raddr,
                                    input wb_req_t              p0,
                                    input wb_req_t              p1);
        return pend[raddr] & ~(p0.vld & (p0.waddr == raddr))
                           & ~(p1.vld & (p1.waddr == raddr));
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard for decode RAW stalls; compiled only when
// GPR_WB_SCOREBOARD_EN is defined.
`ifdef GPR_WB_SCOREBOARD_EN
module gpr_scoreboard
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc_vld,
    input  logic [GPR_DEPTH-1:0] i_alloc_addr,
    input  wb_req_t              i_wb0,
    input  wb_req_t              i_wb1,
    input  logic [GPR_DEPTH-1:0] i_raddr0,
    input  logic [GPR_DEPTH-1:0] i_raddr1,
    input  logic [GPR_DEPTH-1:0] i_raddr2,
    output logic                 o_busy0,
    output logic                 o_busy1,
    output logic                 o_busy2
);

    logic [GPR_SIZE-1:0] r_pending;
    logic [GPR_SIZE-1:0] w_pend_nxt;

    // Clears first, then set, so a same-cycle alloc of a committing register stays pending.
    always_comb begin
        w_pend_nxt = r_pending;
        if (i_wb0.vld) w_pend_nxt[i_wb0.waddr] = 1'b0;
        if (i_wb1.vld) w_pend_nxt[i_wb1.waddr] = 1'b0;
        if (i_alloc_vld) w_pend_nxt[i_alloc_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_pending <= '0;
        else          r_pending <= w_pend_nxt;
    end

    assign o_busy0 = f_busy(r_pending, i_raddr0, i_wb0, i_wb1);
    assign o_busy1 = f_busy(r_pending, i_raddr1, i_wb0, i_wb1);
    assign o_busy2 = f_busy(r_pending, i_raddr2, i_wb0, i_wb1);

endmodule
`endif

// File: rtl/gpr_wb_arbiter.sv
// Merges ALU, LSU and MDU writebacks onto two registered GPR write ports.
// Define GPR_WB_SCOREBOARD_EN to include the pending-register scoreboard.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alu_vld,
    input  logic [GPR_DEPTH-1:0] i_alu_waddr,
    input  logic [GPR_WIDTH-1:0] i_alu_wd,
    input  logic                 i_lsu_vld,
    output logic                 o_lsu_rdy,
    input  logic [GPR_DEPTH-1:0] i_lsu_waddr,
    input  logic [GPR_WIDTH-1:0] i_lsu_wd,
    input  logic                 i_mdu_vld,
    output logic                 o_mdu_rdy,
    input  logic [GPR_DEPTH-1:0] i_mdu_waddr,
    input  logic [GPR_WIDTH-1:0] i_mdu_wd,
    output logic                 o_wr0,
    output logic                 o_wr1,
    output logic [GPR_DEPTH-1:0] o_waddr0,
    output logic [GPR_DEPTH-1:0] o_waddr1,
    output logic [GPR_WIDTH-1:0] o_wd0,
    output logic [GPR_WIDTH-1:0] o_wd1,
    input  logic                 i_alloc_vld,
    input  logic [GPR_DEPTH-1:0] i_alloc_addr,
    input  logic [GPR_DEPTH-1:0] i_raddr0,
    input  logic [GPR_DEPTH-1:0] i_raddr1,
    input  logic [GPR_DEPTH-1:0] i_raddr2,
    output logic                 o_busy0,
    output logic                 o_busy1,
    output logic                 o_busy2
);

    wb_req_t w_alu, w_lsu, w_mdu;
    wb_req_t w_p0, w_p1;
    wb_req_t r_p0, r_p1;
    src_e    r_rr;

    logic w_lsu_blk, w_mdu_blk, w_lsu_el, w_mdu_el;
    logic w_pair_limit, w_contend, w_lsu_go, w_mdu_go;

    assign w_alu = '{vld: i_alu_vld, waddr: i_alu_waddr, wd: i_alu_wd};
    assign w_lsu = '{vld: i_lsu_vld, waddr: i_lsu_waddr, wd: i_lsu_wd};
    assign w_mdu = '{vld: i_mdu_vld, waddr: i_mdu_waddr, wd: i_mdu_wd};

    // A request aimed at the ALU's destination cannot issue alongside it.
    assign w_lsu_blk = i_alu_vld & (i_lsu_waddr == i_alu_waddr);
    assign w_mdu_blk = i_alu_vld & (i_mdu_waddr == i_alu_waddr);
    assign w_lsu_el  = i_lsu_vld & ~w_lsu_blk;
    assign w_mdu_el  = i_mdu_vld & ~w_mdu_blk;

    // Only one of LSU/MDU fits when the ALU holds a port or both target the same register.
    assign w_pair_limit = i_alu_vld | (i_lsu_waddr == i_mdu_waddr);
    assign w_contend    = w_lsu_el & w_mdu_el & w_pair_limit;

    // Each rdy looks only at the other source's vld so the handshake has no loop.
    assign o_lsu_rdy = i_rst_n & ~w_lsu_blk & ~(w_mdu_el & w_pair_limit & (r_rr != SRC_LSU));
    assign o_mdu_rdy = i_rst_n & ~w_mdu_blk & ~(w_lsu_el & w_pair_limit & (r_rr == SRC_LSU));

    assign w_lsu_go = i_lsu_vld & o_lsu_rdy;
    assign w_mdu_go = i_mdu_vld & o_mdu_rdy;

    always_comb begin
        w_p0 = '0;
        w_p1 = '0;
        if (i_alu_vld) begin
            w_p0 = w_alu;
            if (w_lsu_go)      w_p1 = w_lsu;
            else if (w_mdu_go) w_p1 = w_mdu;
        end else if (w_lsu_go) begin
            w_p0 = w_lsu;
            if (w_mdu_go) w_p1 = w_mdu;
        end else if (w_mdu_go) begin
            w_p0 = w_mdu;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_rr <= RR_RST;
        end else begin
            r_p0 <= w_p0;
            r_p1 <= w_p1;
            if (w_contend) r_rr <= (r_rr == SRC_LSU) ? SRC_MDU : SRC_LSU;
        end
    end

    assign o_wr0    = r_p0.vld;
    assign o_waddr0 = r_p0.waddr;
    assign o_wd0    = r_p0.wd;
    assign o_wr1    = r_p1.vld;
    assign o_waddr1 = r_p1.waddr;
    assign o_wd1    = r_p1.wd;

`ifdef GPR_WB_SCOREBOARD_EN
    gpr_scoreboard u_scoreboard (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_alloc_vld  (i_alloc_vld),
        .i_alloc_addr (i_alloc_addr),
        .i_wb0        (r_p0),
        .i_wb1        (r_p1),
        .i_raddr0     (i_raddr0),
        .i_raddr1     (i_raddr1),
        .i_raddr2     (i_raddr2),
        .o_busy0      (o_busy0),
        .o_busy1      (o_busy1),
        .o_busy2      (o_busy2)
    );
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{i_alloc_vld, i_alloc_addr, i_raddr0, i_raddr1, i_raddr2};
    assign o_busy0 = 1'b0;
    assign o_busy1 = 1'b0;
    assign o_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed vector bench for gpr_wb_arbiter: arbitration table plus reset and
// scoreboard sequences.
module tb_gpr_wb_arbiter;

`ifdef GPR_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk, rst_n;
    logic        alu_vld, lsu_vld, mdu_vld, lsu_rdy, mdu_rdy;
    logic [4:0]  alu_waddr, lsu_waddr, mdu_waddr;
    logic [31:0] alu_wd, lsu_wd, mdu_wd;
    logic        wr0, wr1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wd0, wd1;
    logic        alloc_vld;
    logic [4:0]  alloc_addr, raddr0, raddr1, raddr2;
    logic        busy0, busy1, busy2;

    int total = 0;
    int bad   = 0;

    gpr_wb_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_vld(alu_vld), .i_alu_waddr(alu_waddr), .i_alu_wd(alu_wd),
        .i_lsu_vld(lsu_vld), .o_lsu_rdy(lsu_rdy), .i_lsu_waddr(lsu_waddr), .i_lsu_wd(lsu_wd),
        .i_mdu_vld(mdu_vld), .o_mdu_rdy(mdu_rdy), .i_mdu_waddr(mdu_waddr), .i_mdu_wd(mdu_wd),
        .o_wr0(wr0), .o_wr1(wr1), .o_waddr0(waddr0), .o_waddr1(waddr1),
        .o_wd0(wd0), .o_wd1(wd1),
        .i_alloc_vld(alloc_vld), .i_alloc_addr(alloc_addr),
        .i_raddr0(raddr0), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_busy0(busy0), .o_busy1(busy1), .o_busy2(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        alu_vld;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        lsu_vld;
        logic [4:0]  lsu_a;
        logic [31:0] lsu_d;
        logic        mdu_vld;
        logic [4:0]  mdu_a;
        logic [31:0] mdu_d;
        logic        e_lrdy;
        logic        e_mrdy;
        logic        e_wr0;
        logic [4:0]  e_a0;
        logic [31:0] e_d0;
        logic        e_wr1;
        logic [4:0]  e_a1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_vld = 1'b0; alu_waddr = 5'd0; alu_wd = 32'h0;
        lsu_vld = 1'b0; lsu_waddr = 5'd0; lsu_wd = 32'h0;
        mdu_vld = 1'b0; mdu_waddr = 5'd0; mdu_wd = 32'h0;
        alloc_vld = 1'b0; alloc_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ports(input string tag, input logic ewr0, input logic [4:0] ea0,
                             input logic [31:0] ed0, input logic ewr1,
                             input logic [4:0] ea1, input logic [31:0] ed1);
        chk({tag, " wr0"}, {31'd0, wr0}, {31'd0, ewr0});
        chk({tag, " waddr0"}, {27'd0, waddr0}, {27'd0, ea0});
        chk({tag, " wd0"}, wd0, ed0);
        chk({tag, " wr1"}, {31'd0, wr1}, {31'd0, ewr1});
        chk({tag, " waddr1"}, {27'd0, waddr1}, {27'd0, ea1});
        chk({tag, " wd1"}, wd1, ed1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // alu(v,a,d) lsu(v,a,d) mdu(v,a,d) | lsu_rdy mdu_rdy | port0 | port1 ; rr tracked by hand
        tv[0]  = {1'b1,5'd3,32'h11,   1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,
                  1'b1,1'b1, 1'b1,5'd3,32'h11,   1'b0,5'd0,32'h0};
        tv[1]  = {1'b1,5'd1,32'hA1,   1'b1,5'd2,32'hB2,   1'b1,5'd4,32'hC4,
                  1'b1,1'b0, 1'b1,5'd1,32'hA1,   1'b1,5'd2,32'hB2};   // rr -> MDU
        tv[2]  = {1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b1,5'd4,32'hC4,
                  1'b1,1'b1, 1'b1,5'd4,32'hC4,   1'b0,5'd0,32'h0};
        tv[3]  = {1'b1,5'd5,32'h55,   1'b1,5'd5,32'h66,   1'b0,5'd0,32'h0,
                  1'b0,1'b1, 1'b1,5'd5,32'h55,   1'b0,5'd0,32'h0};
        tv[4]  = {1'b0,5'd0,32'h0,    1'b1,5'd5,32'h66,   1'b0,5'd0,32'h0,
                  1'b1,1'b1, 1'b1,5'd5,32'h66,   1'b0,5'd0,32'h0};
        tv[5]  = {1'b1,5'd10,32'hAA,  1'b1,5'd11,32'hBB,  1'b1,5'd12,32'hCC,
                  1'b0,1'b1, 1'b1,5'd10,32'hAA,  1'b1,5'd12,32'hCC};  // rr -> LSU
        tv[6]  = {1'b0,5'd0,32'h0,    1'b1,5'd11,32'hBB,  1'b0,5'd0,32'h0,
                  1'b1,1'b1, 1'b1,5'd11,32'hBB,  1'b0,5'd0,32'h0};
        tv[7]  = {1'b0,5'd0,32'h0,    1'b1,5'd7,32'h77,   1'b1,5'd7,32'h78,
                  1'b1,1'b0, 1'b1,5'd7,32'h77,   1'b0,5'd0,32'h0};    // rr -> MDU
        tv[8]  = {1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b1,5'd7,32'h78,
                  1'b1,1'b1, 1'b1,5'd7,32'h78,   1'b0,5'd0,32'h0};
        tv[9]  = {1'b0,5'd0,32'h0,    1'b1,5'd2,32'h22,   1'b1,5'd3,32'h33,
                  1'b1,1'b1, 1'b1,5'd2,32'h22,   1'b1,5'd3,32'h33};
        tv[10] = {1'b1,5'd8,32'h88,   1'b0,5'd0,32'h0,    1'b1,5'd9,32'h99,
                  1'b0,1'b1, 1'b1,5'd8,32'h88,   1'b1,5'd9,32'h99};
        tv[11] = {1'b1,5'd6,32'h66,   1'b0,5'd0,32'h0,    1'b1,5'd6,32'h67,
                  1'b1,1'b0, 1'b1,5'd6,32'h66,   1'b0,5'd0,32'h0};
        tv[12] = {1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,
                  1'b1,1'b1, 1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0};

        rst_n = 1'b0;
        idle_inputs();
        raddr0 = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
        lsu_vld = 1'b1; lsu_waddr = 5'd2; lsu_wd = 32'h5;
        repeat (3) step();
        chk("reset lsu_rdy", {31'd0, lsu_rdy}, 32'd0);
        chk("reset mdu_rdy", {31'd0, mdu_rdy}, 32'd0);
        chk_ports("reset", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            alu_vld = tv[i].alu_vld; alu_waddr = tv[i].alu_a; alu_wd = tv[i].alu_d;
            lsu_vld = tv[i].lsu_vld; lsu_waddr = tv[i].lsu_a; lsu_wd = tv[i].lsu_d;
            mdu_vld = tv[i].mdu_vld; mdu_waddr = tv[i].mdu_a; mdu_wd = tv[i].mdu_d;
            #1;
            chk($sformatf("v%0d lsu_rdy", i), {31'd0, lsu_rdy}, {31'd0, tv[i].e_lrdy});
            chk($sformatf("v%0d mdu_rdy", i), {31'd0, mdu_rdy}, {31'd0, tv[i].e_mrdy});
            step();
            chk_ports($sformatf("v%0d", i), tv[i].e_wr0, tv[i].e_a0, tv[i].e_d0,
                      tv[i].e_wr1, tv[i].e_a1, tv[i].e_d1);
        end

        // Reset mid-stream: rr is MDU here and r13 is pending beforehand.
        @(negedge clk);
        idle_inputs();
        alu_vld = 1'b1; alu_waddr = 5'd1; alu_wd = 32'h01;
        alloc_vld = 1'b1; alloc_addr = 5'd13;
        raddr0 = 5'd13;
        step();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        lsu_vld = 1'b1; lsu_waddr = 5'd13; lsu_wd = 32'hDD;
        mdu_vld = 1'b1; mdu_waddr = 5'd14; mdu_wd = 32'hEE;
        #1;
        chk("rst lsu_rdy", {31'd0, lsu_rdy}, 32'd0);
        chk("rst mdu_rdy", {31'd0, mdu_rdy}, 32'd0);
        chk("pre-rst busy0", {31'd0, busy0}, {31'd0, SB});
        step();
        chk_ports("rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("rst busy0", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_vld = 1'b1; alu_waddr = 5'd20; alu_wd = 32'h20;
        #1;
        chk("post-rst lsu_rdy", {31'd0, lsu_rdy}, 32'd1);
        chk("post-rst mdu_rdy", {31'd0, mdu_rdy}, 32'd0);
        step();
        chk_ports("post-rst", 1'b1, 5'd20, 32'h20, 1'b1, 5'd13, 32'hDD);

        // Scoreboard: alloc r9, MDU writes r9 three cycles later, realloc while committing.
        @(negedge clk);
        idle_inputs();
        alloc_vld = 1'b1; alloc_addr = 5'd9;
        raddr0 = 5'd9; raddr1 = 5'd9; raddr2 = 5'd10;
        step();
        chk("sb t+1 busy0", {31'd0, busy0}, {31'd0, SB});
        chk("sb t+1 busy2", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        alloc_vld = 1'b0;
        step();
        chk("sb t+2 busy0", {31'd0, busy0}, {31'd0, SB});
        step();
        @(negedge clk);
        mdu_vld = 1'b1; mdu_waddr = 5'd9; mdu_wd = 32'h9;
        #1;
        chk("sb t+3 mdu_rdy", {31'd0, mdu_rdy}, 32'd1);
        chk("sb t+3 busy0", {31'd0, busy0}, {31'd0, SB});
        step();
        chk_ports("sb t+4", 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
        chk("sb t+4 busy0 bypass", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        mdu_vld = 1'b0;
        alloc_vld = 1'b1; alloc_addr = 5'd9;
        raddr0 = 5'd10;
        #1;
        chk("sb t+4 busy1 bypass", {31'd0, busy1}, 32'd0);
        step();
        chk("sb set-wins busy1", {31'd0, busy1}, {31'd0, SB});
        chk("sb t+5 busy0 r10", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
